// File: rtl/lfsr8_prbs_checker.sv
// Self-synchronising receive checker for the 8-bit Fibonacci PRBS (taps 8,6,5,4).
// Seeds a local LFSR from the line, verifies it, then free-runs it to count bit errors.
module lfsr8_prbs_checker #(
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 4,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I,
    input  logic             valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_THRESH + 1);
    localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  MISS_TGT  = MISS_W'(UNLOCK_THRESH);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {ST_FILL, ST_VERIFY, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [7:0]         h_q, h_d;
    logic [2:0]         fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               pred;
    logic               count_err;
    logic [MATCH_W-1:0] match_inc;
    logic [MISS_W-1:0]  miss_inc;

    assign pred      = h_q[7] ^ h_q[5] ^ h_q[4] ^ h_q[3];
    assign match_inc = match_cnt_q + 1'b1;
    assign miss_inc  = miss_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        count_err   = 1'b0;

        if (valid) begin
            case (state_q)
                ST_FILL: begin
                    h_d        = {h_q[6:0], I};
                    fill_cnt_d = fill_cnt_q + 3'd1;
                    if (fill_cnt_q == 3'd7) begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    h_d = {h_q[6:0], I};
                    // A match from the all-zero history proves nothing, so it never advances lock.
                    if ((I == pred) && (h_q != 8'h00)) begin
                        if (match_inc == MATCH_TGT) begin
                            state_d     = ST_LOCKED;
                            locked_d    = 1'b1;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    h_d = {h_q[6:0], pred};
                    if (I != pred) begin
                        err_pulse_d = 1'b1;
                        count_err   = 1'b1;
                        if (miss_inc == MISS_TGT) begin
                            state_d     = ST_FILL;
                            fill_cnt_d  = 3'd0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            locked_d    = 1'b0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end

        err_count_d = err_count_q;
        if (clr_err) begin
            err_count_d = count_err ? CNT_ONE : '0;
        end else if (count_err && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_FILL;
            h_q         <= 8'h00;
            fill_cnt_q  <= 3'd0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr8_prbs_checker.sv
// Bench for lfsr8_prbs_checker: directed scenarios plus random traffic, checked against
// a queue-based reference model through a cycle-by-cycle scoreboard (16-bit and 4-bit counters).
module tb_lfsr8_prbs_checker;
    localparam int LOCK_COUNT    = 16;
    localparam int UNLOCK_THRESH = 4;

    logic        CLK = 1'b0;
    logic        RESET, I, valid, clr_err;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;

    always #5 CLK = ~CLK;

    lfsr8_prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_THRESH(UNLOCK_THRESH), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .I(I), .valid(valid), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    lfsr8_prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_THRESH(UNLOCK_THRESH), .CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .I(I), .valid(valid), .clr_err(clr_err),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    typedef struct packed {
        logic        lk;
        logic        pl;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: history kept as a queue of the last 8 bits, oldest first.
    int   m_mode;   // 0 = fill, 1 = verify, 2 = locked
    bit   m_hist[$];
    int   m_fill, m_match, m_miss, m_c16, m_c4;
    bit   m_pulse;
    logic [7:0] g;

    task automatic hist_push(input bit x);
        m_hist.push_back(x);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit rst, input bit vld, input bit b, input bit clr);
        bit p, err, allzero;
        err = 1'b0;
        if (rst) begin
            m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
            m_c16 = 0; m_c4 = 0; m_pulse = 1'b0;
            m_hist = {};
            repeat (8) m_hist.push_back(1'b0);
        end else begin
            m_pulse = 1'b0;
            if (vld) begin
                // newest bit is m_hist[7]; generator taps 8,6,5,4 are the 8th,6th,5th,4th most recent
                p = m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[4];
                allzero = 1'b1;
                foreach (m_hist[k]) if (m_hist[k]) allzero = 1'b0;
                case (m_mode)
                    0: begin
                        hist_push(b);
                        m_fill++;
                        if (m_fill == 8) begin m_mode = 1; m_fill = 0; end
                    end
                    1: begin
                        if (b == p && !allzero) m_match++;
                        else m_match = 0;
                        hist_push(b);
                        if (m_match == LOCK_COUNT) begin m_mode = 2; m_match = 0; end
                    end
                    default: begin
                        hist_push(p);
                        if (b != p) begin
                            err = 1'b1;
                            m_pulse = 1'b1;
                            m_miss++;
                            if (m_miss == UNLOCK_THRESH) begin
                                m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
                            end
                        end else begin
                            m_miss = 0;
                        end
                    end
                endcase
            end
            if (clr) begin
                m_c16 = err ? 1 : 0;
                m_c4  = err ? 1 : 0;
            end else if (err) begin
                if (m_c16 < 65535) m_c16++;
                if (m_c4 < 15) m_c4++;
            end
        end
    endtask

    task automatic gen(output bit b);
        b = g[7] ^ g[5] ^ g[4] ^ g[3];
        g = {g[6:0], b};
    endtask

    task automatic send(input bit rst, input bit b, input bit vld, input bit clr);
        exp_t e;
        @(negedge CLK);
        RESET = rst; I = b; valid = vld; clr_err = clr;
        model_step(rst, vld, b, clr);
        e.lk  = (m_mode == 2);
        e.pl  = m_pulse;
        e.c16 = 16'(m_c16);
        e.c4  = 4'(m_c4);
        exp_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: one expected tuple per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (locked !== e.lk || err_pulse !== e.pl || err_count !== e.c16 ||
                    locked4 !== e.lk || err_pulse4 !== e.pl || err_count4 !== e.c4) begin
                    n_fail++;
                    if (n_fail <= 40)
                        $display("FAIL scoreboard @%0t: got lk=%0b/%0b pl=%0b/%0b cnt=%0d/%0d expected lk=%0b pl=%0b cnt=%0d/%0d",
                                 $time, locked, locked4, err_pulse, err_pulse4, err_count, err_count4,
                                 e.lk, e.pl, e.c16, e.c4);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b, v, c, r, flip, rb;
        RESET = 1'b1; I = 1'b0; valid = 1'b0; clr_err = 1'b0; g = 8'h01;
        repeat (3) send(1, 0, 0, 0);
        chk("reset_locked", locked, 0);
        chk("reset_pulse", err_pulse, 0);
        chk("reset_cnt", err_count, 0);

        // Case 1: clean stream from seed 01
        g = 8'h01;
        for (int k = 1; k <= 24; k++) begin
            gen(b); send(0, b, 1, 0);
            if (k == 23) chk("no_lock_before_24", locked, 0);
        end
        chk("lock_at_24", locked, 1);
        repeat (1000) begin gen(b); send(0, b, 1, 0); end
        chk("clean_1000_cnt", err_count, 0);
        chk("clean_1000_locked", locked, 1);

        // Case 2: one isolated error
        gen(b); send(0, !b, 1, 0);
        chk("single_pulse", err_pulse, 1);
        chk("single_cnt", err_count, 1);
        chk("single_locked", locked, 1);
        gen(b); send(0, b, 1, 0);
        chk("pulse_one_cycle", err_pulse, 0);
        repeat (30) begin gen(b); send(0, b, 1, 0); end
        chk("single_cnt_after", err_count, 1);

        // Case 3: burst of 4 errors -> unlock, relock
        gen(b); send(0, b, 1, 1);
        chk("clr_alone", err_count, 0);
        for (int k = 1; k <= 4; k++) begin
            gen(b); send(0, !b, 1, 0);
            if (k == 3) chk("locked_after_3_errs", locked, 1);
        end
        chk("unlock_after_4", locked, 0);
        chk("burst_cnt", err_count, 4);
        for (int k = 1; k <= 24; k++) begin
            gen(b); send(0, b, 1, 0);
            if (k == 23) chk("no_relock_before_24", locked, 0);
        end
        chk("relock_24", locked, 1);
        chk("cnt_held_relock", err_count, 4);

        // Case 4: all-zero stream never locks, then a real sequence locks
        send(1, 0, 0, 0);
        repeat (200) send(0, 0, 1, 0);
        chk("zeros_locked", locked, 0);
        chk("zeros_cnt", err_count, 0);
        g = 8'h01;
        repeat (64) begin gen(b); send(0, b, 1, 0); end
        chk("lock_after_zeros", locked, 1);

        // Case 5: valid toggling every cycle
        send(1, 0, 0, 0);
        g = 8'h01;
        for (int k = 1; k <= 24; k++) begin
            gen(b); send(0, b, 1, 0);
            rb = 1'($urandom_range(0, 1));
            send(0, rb, 0, 0);
            if (k == 23) chk("toggle_no_lock_23", locked, 0);
        end
        chk("toggle_lock_24", locked, 1);
        repeat (100) begin
            gen(b); send(0, b, 1, 0);
            rb = 1'($urandom_range(0, 1));
            send(0, rb, 0, 0);
        end
        chk("toggle_clean_cnt", err_count, 0);
        gen(b); send(0, !b, 1, 0);
        repeat (10) begin gen(b); send(0, b, 1, 0); end
        chk("toggle_pre_clr_cnt", err_count, 1);
        gen(b); send(0, !b, 1, 1);
        chk("clr_with_err", err_count, 1);

        // Case 6: saturation of the 4-bit counter, then reset while locked
        gen(b); send(0, b, 1, 1);
        repeat (20) begin
            repeat (9) begin gen(b); send(0, b, 1, 0); end
            gen(b); send(0, !b, 1, 0);
        end
        chk("sat4_cnt", err_count4, 15);
        chk("cnt16_20", err_count, 20);
        chk("sat_locked", locked, 1);
        gen(b); send(1, b, 1, 0);
        chk("reset_mid_locked", locked, 0);
        chk("reset_mid_cnt", err_count, 0);
        chk("reset_mid_cnt4", err_count4, 0);

        // Random traffic: sparse errors, valid gaps, clears and resets
        g = 8'h5A;
        repeat (2000) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            r = ($urandom_range(0, 299) == 0);
            if (v) begin
                gen(b);
                flip = ($urandom_range(0, 19) == 0);
                send(r, b ^ flip, 1, c);
            end else begin
                rb = 1'($urandom_range(0, 1));
                send(r, rb, 0, c);
            end
        end

        repeat (2) @(posedge CLK);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
